hilo_div_ctrl: RTL and testbench

//  Sequencer and HI/LO owner for the multi-cycle unsigned divider (DIVU) in the CPU54 core.

---
 rtl/hilo_div_ctrl_if.sv | 30 +++
 rtl/hilo_div_ctrl.sv | 102 ++++++++++
 tb/tb_hilo_div_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_div_ctrl_if.sv
// Bundle of signals between the execute stage, the HI/LO divide sequencer and the DIVU divider.
// The slave side is the sequencer. The master side is the pipeline together with the divider.
interface hilo_div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_start;
  logic             div_busy;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  modport master (
    output op_valid, op, rs_data, rt_data, div_busy, div_q, div_r,
    input  stall, hi, lo, div_zero, div_dividend, div_divisor, div_start
  );

  modport slave (
    input  op_valid, op, rs_data, rt_data, div_busy, div_q, div_r,
    output stall, hi, lo, div_zero, div_dividend, div_divisor, div_start
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO owner and sequencer for the multi-cycle unsigned divider.
// Signed DIV runs as a magnitude divide followed by a sign fix-up. State advances on the falling clock edge.
module hilo_div_ctrl #(
  parameter int WIDTH         = 32,
  parameter bit SKIP_DIV_ZERO = 1'b1
) (
  input logic            clock,
  input logic            reset,
  hilo_div_ctrl_if.slave bus
);
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIX} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] hi_q, lo_q, dividend_q, divisor_q;
  logic             neg_q, neg_r, div_zero_q;
  logic             is_div, is_signed, rt_zero, launch, zero_skip, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  // Decode the execute-stage op. The operand magnitudes are only meaningful for signed DIV.
  always_comb begin
    is_div    = bus.op_valid && (bus.op == OP_DIV || bus.op == OP_DIVU);
    is_signed = (bus.op == OP_DIV);
    rt_zero   = (bus.rt_data == '0);
    launch    = (state == S_IDLE) && is_div && !(SKIP_DIV_ZERO && rt_zero);
    zero_skip = (state == S_IDLE) && is_div && SKIP_DIV_ZERO && rt_zero;
    rs_neg    = is_signed && bus.rs_data[WIDTH-1];
    rt_neg    = is_signed && bus.rt_data[WIDTH-1];
    rs_mag    = rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
    rt_mag    = rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.stall     = 1'b1;
    bus.div_start = 1'b0;
    case (state)
      S_IDLE: begin
        bus.stall = launch;
        if (launch) next_state = S_LAUNCH;
      end
      S_LAUNCH: begin
        bus.div_start = 1'b1;
        next_state    = S_WAIT;
      end
      S_WAIT:  if (!bus.div_busy) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The remainder takes the dividend's sign. The quotient is negative when the operand signs differ.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      div_zero_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            dividend_q <= rs_mag;
            divisor_q  <= rt_mag;
            neg_q      <= rs_neg ^ rt_neg;
            neg_r      <= rs_neg;
          end else if (zero_skip) begin
            div_zero_q <= 1'b1;
          end else if (bus.op_valid && bus.op == OP_MTHI) begin
            hi_q <= bus.rs_data;
          end else if (bus.op_valid && bus.op == OP_MTLO) begin
            lo_q <= bus.rs_data;
          end
        end
        S_FIX: begin
          lo_q <= neg_q ? (~bus.div_q + 1'b1) : bus.div_q;
          hi_q <= neg_r ? (~bus.div_r + 1'b1) : bus.div_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.div_zero     = div_zero_q;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: a behavioural 32-cycle divider plus a scoreboard of {hi,lo} results.
// Each test task drives one scenario and checks its own results.
module tb_hilo_div_ctrl;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] exp_q[$];
  int   div_cnt;

  hilo_div_ctrl_if #(.WIDTH(32)) bus ();

  hilo_div_ctrl #(.WIDTH(32), .SKIP_DIV_ZERO(1'b1)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // The divider raises busy on the edge that sees start, and drops it 32 edges later.
  always @(negedge clock or posedge reset) begin
    if (reset) begin
      bus.div_busy <= 1'b0;
      bus.div_q    <= '0;
      bus.div_r    <= '0;
      div_cnt      <= 0;
    end else if (bus.div_start) begin
      bus.div_busy <= 1'b1;
      div_cnt      <= 31;
      bus.div_q    <= (bus.div_divisor == 0) ? 32'hFFFF_FFFF : bus.div_dividend / bus.div_divisor;
      bus.div_r    <= (bus.div_divisor == 0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;
    end else if (bus.div_busy) begin
      if (div_cnt == 0) bus.div_busy <= 1'b0;
      else              div_cnt <= div_cnt - 1;
    end
  end

  function automatic logic [63:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (op == OP_DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] ref_mag(input logic [2:0] op, input logic [31:0] a);
    longint sa;
    sa = (op == OP_DIV) ? longint'($signed(a)) : longint'({32'd0, a});
    if (sa < 0) sa = -sa;
    return sa[31:0];
  endfunction

  task automatic issue_mt(input logic [2:0] op, input logic [31:0] val);
    @(posedge clock);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.rs_data  = val;
    @(negedge clock);
    #1 bus.op_valid = 1'b0;
  endtask

  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stall_cnt, output int start_cnt);
    bit done;
    stall_cnt = 0;
    start_cnt = 0;
    done      = 0;
    @(posedge clock);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.rs_data  = a;
    bus.rt_data  = b;
    exp_q.push_back(ref_div(op, a, b));
    @(negedge clock);
    #1 bus.op_valid = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clock);
      if (bus.div_start) start_cnt++;
      if (bus.stall) stall_cnt++;
      else           done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL div_timeout: stall still high after %0d cycles, required low", stall_cnt);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = 3'b000;
    bus.rs_data  = '0;
    bus.rt_data  = '0;
    repeat (3) @(posedge clock);
    total++; if (bus.hi !== 32'h0) begin bad++; $display("[TB] FAIL reset_hi: got %h want 0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("[TB] FAIL reset_lo: got %h want 0", bus.lo); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", bus.stall); end
    total++; if (bus.div_zero !== 1'b0) begin bad++; $display("[TB] FAIL reset_div_zero: got %b want 0", bus.div_zero); end
    total++; if (bus.div_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_div_start: got %b want 0", bus.div_start); end
    reset = 1'b0;
  endtask

  task automatic test_divu_basic();
    int sc, st;
    logic [63:0] e;
    run_div(OP_DIVU, 32'd100, 32'd7, sc, st);
    e = exp_q.pop_front();
    total++; if (sc != 35) begin bad++; $display("[TB] FAIL divu_stall_cycles: got %0d want 35", sc); end
    total++; if (st != 1) begin bad++; $display("[TB] FAIL divu_start_cycles: got %0d want 1", st); end
    total++; if (bus.lo !== e[31:0]) begin bad++; $display("[TB] FAIL divu_lo: got %h want %h", bus.lo, e[31:0]); end
    total++; if (bus.hi !== e[63:32]) begin bad++; $display("[TB] FAIL divu_hi: got %h want %h", bus.hi, e[63:32]); end
  endtask

  task automatic test_div_signed();
    logic [2:0]  ops[8];
    logic [31:0] as[8];
    logic [31:0] bs[8];
    int sc, st;
    logic [63:0] e;
    ops = '{OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
    as  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0};
    bs  = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0};
    for (int i = 4; i < 8; i++) begin
      as[i] = $urandom;
      bs[i] = $urandom >> $urandom_range(0, 28);
      if (bs[i] == 0) bs[i] = 32'd3;
    end
    for (int i = 0; i < 8; i++) begin
      run_div(ops[i], as[i], bs[i], sc, st);
      e = exp_q.pop_front();
      total++;
      if (bus.lo !== e[31:0]) begin bad++; $display("[TB] FAIL div_lo[%0d]: got %h want %h", i, bus.lo, e[31:0]); end
      total++;
      if (bus.hi !== e[63:32]) begin bad++; $display("[TB] FAIL div_hi[%0d]: got %h want %h", i, bus.hi, e[63:32]); end
      total++;
      if (bus.div_dividend !== ref_mag(ops[i], as[i])) begin
        bad++; $display("[TB] FAIL div_dividend[%0d]: got %h want %h", i, bus.div_dividend, ref_mag(ops[i], as[i]));
      end
      total++;
      if (bus.div_divisor !== ref_mag(ops[i], bs[i])) begin
        bad++; $display("[TB] FAIL div_divisor[%0d]: got %h want %h", i, bus.div_divisor, ref_mag(ops[i], bs[i]));
      end
    end
  endtask

  task automatic test_div_zero();
    issue_mt(OP_MTHI, 32'h1234);
    issue_mt(OP_MTLO, 32'h1234);
    @(posedge clock);
    bus.op_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.rs_data  = 32'd5;
    bus.rt_data  = 32'd0;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("[TB] FAIL dz_stall: got %b want 0", bus.stall); end
    @(negedge clock);
    #1 bus.op_valid = 1'b0;
    @(posedge clock);
    total++; if (bus.div_zero !== 1'b1) begin bad++; $display("[TB] FAIL dz_pulse: got %b want 1", bus.div_zero); end
    total++; if (bus.hi !== 32'h1234) begin bad++; $display("[TB] FAIL dz_hi: got %h want 1234", bus.hi); end
    total++; if (bus.lo !== 32'h1234) begin bad++; $display("[TB] FAIL dz_lo: got %h want 1234", bus.lo); end
    total++; if (bus.div_start !== 1'b0) begin bad++; $display("[TB] FAIL dz_start: got %b want 0", bus.div_start); end
    @(posedge clock);
    total++; if (bus.div_zero !== 1'b0) begin bad++; $display("[TB] FAIL dz_pulse_end: got %b want 0", bus.div_zero); end
  endtask

  task automatic test_reset_mid_divide();
    int sc, st;
    logic [63:0] e;
    @(posedge clock);
    bus.op_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.rs_data  = 32'h1000;
    bus.rt_data  = 32'd3;
    @(negedge clock);
    #1 bus.op_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (bus.hi !== 32'h0) begin bad++; $display("[TB] FAIL rst_mid_hi: got %h want 0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("[TB] FAIL rst_mid_lo: got %h want 0", bus.lo); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_stall: got %b want 0", bus.stall); end
    @(posedge clock);
    reset = 1'b0;
    run_div(OP_DIVU, 32'd9, 32'd3, sc, st);
    e = exp_q.pop_front();
    total++; if (bus.lo !== e[31:0]) begin bad++; $display("[TB] FAIL rst_next_lo: got %h want %h", bus.lo, e[31:0]); end
    total++; if (bus.hi !== e[63:32]) begin bad++; $display("[TB] FAIL rst_next_hi: got %h want %h", bus.hi, e[63:32]); end
  endtask

  task automatic test_mthi_during_wait();
    bit done;
    logic [63:0] e;
    done = 0;
    @(posedge clock);
    bus.op_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.rs_data  = 32'd1000;
    bus.rt_data  = 32'd33;
    exp_q.push_back(ref_div(OP_DIVU, 32'd1000, 32'd33));
    @(negedge clock);
    #1 bus.op_valid = 1'b0;
    repeat (5) @(posedge clock);
    bus.op_valid = 1'b1;
    bus.op       = OP_MTHI;
    bus.rs_data  = 32'hA;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clock);
      if (!bus.stall) done = 1;
    end
    total++; if (!done) begin bad++; $display("[TB] FAIL mthi_wait_timeout: stall high, want low"); end
    e = exp_q.pop_front();
    total++; if (bus.hi !== e[63:32]) begin bad++; $display("[TB] FAIL mthi_div_hi: got %h want %h", bus.hi, e[63:32]); end
    total++; if (bus.lo !== e[31:0]) begin bad++; $display("[TB] FAIL mthi_div_lo: got %h want %h", bus.lo, e[31:0]); end
    @(negedge clock);
    #1 bus.op_valid = 1'b0;
    @(posedge clock);
    total++; if (bus.hi !== 32'hA) begin bad++; $display("[TB] FAIL mthi_final_hi: got %h want a", bus.hi); end
    total++; if (bus.lo !== e[31:0]) begin bad++; $display("[TB] FAIL mthi_final_lo: got %h want %h", bus.lo, e[31:0]); end
  endtask

  task automatic test_back_to_back();
    int sc1, st1, sc2, st2;
    logic [63:0] e;
    run_div(OP_DIV, 32'hFFFF_FF00, 32'd10, sc1, st1);
    e = exp_q.pop_front();
    total++; if (bus.lo !== e[31:0]) begin bad++; $display("[TB] FAIL b2b_lo0: got %h want %h", bus.lo, e[31:0]); end
    total++; if (bus.hi !== e[63:32]) begin bad++; $display("[TB] FAIL b2b_hi0: got %h want %h", bus.hi, e[63:32]); end
    run_div(OP_DIVU, 32'hDEAD_BEEF, 32'h1234, sc2, st2);
    e = exp_q.pop_front();
    total++; if (bus.lo !== e[31:0]) begin bad++; $display("[TB] FAIL b2b_lo1: got %h want %h", bus.lo, e[31:0]); end
    total++; if (bus.hi !== e[63:32]) begin bad++; $display("[TB] FAIL b2b_hi1: got %h want %h", bus.hi, e[63:32]); end
    total++; if (sc2 != 35) begin bad++; $display("[TB] FAIL b2b_stall_cycles: got %0d want 35", sc2); end
    total++; if (st2 != 1) begin bad++; $display("[TB] FAIL b2b_start_cycles: got %0d want 1", st2); end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_div_zero();
    test_reset_mid_divide();
    test_mthi_during_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
